// File: rtl/gated_clk_en_ctrl.sv
// Idle-detect clock-enable controller for one gated clock cell.
// Drops local_en after a programmable idle window, restores it on a wake
// condition and holds unit_ready low for a fixed warm-up period.
//
// Interface semantics: this block has no valid/ready handshake. gate_allow,
// unit_busy and wake_req are plain levels sampled on every rising edge of
// clk_in. wake_ack is a one-cycle pulse that is not acknowledged back.
module gated_clk_en_ctrl #(
  parameter int IDLE_CYCLES = 16,
  parameter int WAKE_CYCLES = 2,
  parameter int CNT_W       = 8
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       gate_allow,
  input  logic       unit_busy,
  input  logic       wake_req,
  input  logic       pad_yy_gate_clk_en_b,
  output logic       local_en,
  output logic       unit_ready,
  output logic       gated,
  output logic       wake_ack,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_IDLE_CNT = 2'd1,
    S_GATED    = 2'd2,
    S_WAKE     = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] IDLE_LOAD = CNT_W'(IDLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAKE_LOAD = CNT_W'(WAKE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_local_en_q;
  logic               r_unit_ready;
  logic               r_gated;
  logic               r_wake_ack;

  state_t             w_next_state;
  logic [CNT_W-1:0]   w_next_cnt;
  logic               w_idle;

  // Next-state and counter selection; bypass forces RUN from any state.
  always_comb begin
    w_idle       = gate_allow & ~unit_busy & ~wake_req;
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    if (pad_yy_gate_clk_en_b) begin
      w_next_state = S_RUN;
      w_next_cnt   = '0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (w_idle) begin
            w_next_state = S_IDLE_CNT;
            w_next_cnt   = IDLE_LOAD;
          end
        end
        S_IDLE_CNT: begin
          // Activity on the final count still wins: no gating.
          if (!w_idle) begin
            w_next_state = S_RUN;
            w_next_cnt   = '0;
          end else if (r_cnt == '0) begin
            w_next_state = S_GATED;
          end else begin
            w_next_cnt = r_cnt - CNT_ONE;
          end
        end
        S_GATED: begin
          // Any reason to leave (wake, busy, permission withdrawn) is one entry.
          if (!w_idle) begin
            w_next_state = S_WAKE;
            w_next_cnt   = WAKE_LOAD;
          end
        end
        S_WAKE: begin
          // Inputs are ignored while warming up; a wake cannot be aborted.
          if (r_cnt == '0) begin
            w_next_state = S_RUN;
          end else begin
            w_next_cnt = r_cnt - CNT_ONE;
          end
        end
        default: begin
          w_next_state = S_RUN;
          w_next_cnt   = '0;
        end
      endcase
    end
  end

  // State, counter and registered outputs decoded from the next state.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_state      <= S_RUN;
      r_cnt        <= '0;
      r_local_en_q <= 1'b1;
      r_unit_ready <= 1'b1;
      r_gated      <= 1'b0;
      r_wake_ack   <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_cnt        <= w_next_cnt;
      r_local_en_q <= (w_next_state != S_GATED);
      r_unit_ready <= (w_next_state == S_RUN) || (w_next_state == S_IDLE_CNT);
      r_gated      <= (w_next_state == S_GATED);
      r_wake_ack   <= !pad_yy_gate_clk_en_b && (r_state == S_WAKE) &&
                      (w_next_state == S_RUN);
    end
  end

  // Bypass forces the clock on without waiting for an edge.
  assign local_en   = r_local_en_q | pad_yy_gate_clk_en_b;
  assign unit_ready = r_unit_ready;
  assign gated      = r_gated;
  assign wake_ack   = r_wake_ack;
  assign dbg_state  = r_state;

endmodule
